// File: rtl/coproc_pkg.sv
// Shared types and constants for the image coprocessor front end.
package coproc_pkg;

    localparam int PIX_W      = 12;
    localparam int WIN_W      = 36;
    localparam int DEF_IMG_W  = 160;
    localparam int DEF_IMG_H  = 120;
    localparam int DEF_ADDR_W = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2
    } feeder_state_t;

    typedef logic [PIX_W-1:0] pix_t;

    // One window column: rows y-1, y, y+1 at a single x.
    typedef struct packed {
        pix_t top;
        pix_t mid;
        pix_t bot;
    } win_col_t;

    localparam pix_t             PIX_ZERO = 12'h000;
    localparam win_col_t         COL_ZERO = {PIX_ZERO, PIX_ZERO, PIX_ZERO};
    localparam logic [WIN_W-1:0] WIN_ZERO = 36'h0_0000_0000;

    function automatic logic [WIN_W-1:0] pack_row(input pix_t l, input pix_t c, input pix_t r);
        return {l, c, r};
    endfunction

endpackage

// File: rtl/window_feeder_if.sv
// Source-memory and processing-element signals of the window feeder.
import coproc_pkg::*;

interface window_feeder_if #(parameter int ADDR_W = DEF_ADDR_W);
    logic              go;
    logic              busy;
    logic              src_re;
    logic [ADDR_W-1:0] src_addr;
    pix_t              src_rdata;
    logic [WIN_W-1:0]  rgb_out0;
    logic [WIN_W-1:0]  rgb_out1;
    logic [WIN_W-1:0]  rgb_out2;
    logic              start;
    logic              cnt_start;
    logic              done;

    modport master (
        input  go, src_rdata,
        output busy, src_re, src_addr, rgb_out0, rgb_out1, rgb_out2,
               start, cnt_start, done
    );

    modport slave (
        output go, src_rdata,
        input  busy, src_re, src_addr, rgb_out0, rgb_out1, rgb_out2,
               start, cnt_start, done
    );
endinterface

// File: rtl/line_buffer.sv
// IMG_W-deep circular pixel store: read at the pointer, optional write at
// the same slot, pointer advances once per accepted pixel.
import coproc_pkg::*;

module line_buffer #(
    parameter int IMG_W = DEF_IMG_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic adv,
    input  logic we,
    input  pix_t wdata,
    output pix_t rdata
);

    localparam int              PTR_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(IMG_W - 1);

    logic [PTR_W-1:0] ptr_r;
    pix_t             mem_r [IMG_W];

    // Column pointer, wraps at the end of a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= PTR_ZERO;
        end else if (clr) begin
            ptr_r <= PTR_ZERO;
        end else if (adv) begin
            ptr_r <= (ptr_r == PTR_LAST) ? PTR_ZERO : ptr_r + 1'b1;
        end
    end

    // Pixel storage; no reset, stale contents are masked by the window edge logic.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[ptr_r] <= wdata;
        end
    end

    assign rdata = mem_r[ptr_r];

endmodule

// File: rtl/window_feeder.sv
// Raster 3x3 window source: streams a frame from image memory once and emits
// one neighbourhood per cycle. Define WINDOW_EDGE_REPLICATE_EN for replicate edges.
import coproc_pkg::*;

module window_feeder #(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic            clk,
    input  logic            rst_n,
    window_feeder_if.master bus
);

    localparam int XW = $clog2(IMG_W + 1);
    localparam int YW = $clog2(IMG_H + 2);

    localparam logic [ADDR_W-1:0] ADDR_ZERO       = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_PRIME_LAST = ADDR_W'(IMG_W + 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST       = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [XW-1:0]     X_ZERO          = {XW{1'b0}};
    localparam logic [XW-1:0]     X_LAST          = XW'(IMG_W - 1);
    localparam logic [YW-1:0]     Y_ZERO          = {YW{1'b0}};
    localparam logic [YW-1:0]     Y_ONE           = YW'(1);
    localparam logic [YW-1:0]     Y_LAST          = YW'(IMG_H - 1);

    feeder_state_t     state_r;
    logic              busy_r;
    logic              start_r;
    logic              cnt_start_r;
    logic              done_r;
    logic              src_re_r;
    logic [ADDR_W-1:0] src_addr_r;

    // Arrival side: (px_r, py_r) is the pixel on src_rdata this cycle; it keeps
    // running past the last read so the bottom rows can be drained.
    logic              arr_vld_r;
    logic [XW-1:0]     px_r;
    logic [YW-1:0]     py_r;
    logic [XW-1:0]     cx_r;
    logic [YW-1:0]     cy_r;
    logic              sel_r;

    win_col_t          col_left_r;
    win_col_t          col_mid_r;
    win_col_t          col_new_s;
    logic [WIN_W-1:0]  rgb0_r;
    logic [WIN_W-1:0]  rgb1_r;
    logic [WIN_W-1:0]  rgb2_r;

    pix_t              lb0_rd_s;
    pix_t              lb1_rd_s;
    pix_t              newer_s;
    pix_t              older_s;
    logic              lb0_we_s;
    logic              lb1_we_s;
    logic              go_acc_s;
    logic              win_vld_s;
    logic              last_win_s;

    win_col_t          cols_s [3];
    pix_t              rows_s [3][3];
    pix_t              fld_s  [3][3];

    assign go_acc_s   = (state_r == IDLE) && bus.go;
    assign win_vld_s  = arr_vld_r && ((py_r > Y_ONE) || ((py_r == Y_ONE) && (px_r != X_ZERO)));
    assign last_win_s = (cx_r == X_LAST) && (cy_r == Y_LAST);

    // sel_r names the buffer holding the most recent complete row; the other
    // holds the row before and is overwritten by the incoming row.
    assign newer_s   = sel_r ? lb1_rd_s : lb0_rd_s;
    assign older_s   = sel_r ? lb0_rd_s : lb1_rd_s;
    assign lb0_we_s  = arr_vld_r & sel_r;
    assign lb1_we_s  = arr_vld_r & ~sel_r;
    assign col_new_s = {older_s, newer_s, bus.src_rdata};

    line_buffer #(.IMG_W(IMG_W)) u_lb0 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (go_acc_s),
        .adv   (arr_vld_r),
        .we    (lb0_we_s),
        .wdata (bus.src_rdata),
        .rdata (lb0_rd_s)
    );

    line_buffer #(.IMG_W(IMG_W)) u_lb1 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (go_acc_s),
        .adv   (arr_vld_r),
        .we    (lb1_we_s),
        .wdata (bus.src_rdata),
        .rdata (lb1_rd_s)
    );

    // Frame sequencing, read address generation and arrival/centre tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            start_r     <= 1'b0;
            cnt_start_r <= 1'b0;
            done_r      <= 1'b0;
            src_re_r    <= 1'b0;
            src_addr_r  <= ADDR_ZERO;
            arr_vld_r   <= 1'b0;
            px_r        <= X_ZERO;
            py_r        <= Y_ZERO;
            cx_r        <= X_ZERO;
            cy_r        <= Y_ZERO;
            sel_r       <= 1'b0;
        end else begin
            start_r     <= 1'b0;
            cnt_start_r <= 1'b0;
            done_r      <= 1'b0;

            if (src_re_r) begin
                if (src_addr_r == ADDR_LAST) begin
                    src_re_r   <= 1'b0;
                    src_addr_r <= ADDR_ZERO;
                end else begin
                    src_addr_r <= src_addr_r + 1'b1;
                end
            end

            if (arr_vld_r) begin
                if (px_r == X_LAST) begin
                    px_r  <= X_ZERO;
                    py_r  <= py_r + 1'b1;
                    sel_r <= ~sel_r;
                end else begin
                    px_r <= px_r + 1'b1;
                end
                // Pixel (0,1) arriving means the first window is computed next cycle.
                if ((py_r == Y_ONE) && (px_r == X_ZERO)) begin
                    cnt_start_r <= 1'b1;
                end
                if (win_vld_s) begin
                    if (last_win_s) begin
                        done_r    <= 1'b1;
                        arr_vld_r <= 1'b0;
                    end
                    if (cx_r == X_LAST) begin
                        cx_r <= X_ZERO;
                        cy_r <= cy_r + 1'b1;
                    end else begin
                        cx_r <= cx_r + 1'b1;
                    end
                end
            end

            case (state_r)
                IDLE: begin
                    if (bus.go) begin
                        state_r    <= PRIME;
                        busy_r     <= 1'b1;
                        start_r    <= 1'b1;
                        src_re_r   <= 1'b1;
                        src_addr_r <= ADDR_ZERO;
                        px_r       <= X_ZERO;
                        py_r       <= Y_ZERO;
                        cx_r       <= X_ZERO;
                        cy_r       <= Y_ZERO;
                    end
                end
                PRIME: begin
                    if (start_r) begin
                        arr_vld_r <= 1'b1;
                    end
                    if (src_addr_r == ADDR_PRIME_LAST) begin
                        state_r <= STREAM;
                    end
                end
                STREAM: begin
                    if (done_r) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Two-column history feeding the left and centre window columns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_left_r <= COL_ZERO;
            col_mid_r  <= COL_ZERO;
        end else if (arr_vld_r) begin
            col_left_r <= col_mid_r;
            col_mid_r  <= col_new_s;
        end
    end

    // Edge treatment: rows are fixed first, then columns.
    always_comb begin
        cols_s[0] = col_left_r;
        cols_s[1] = col_mid_r;
        cols_s[2] = col_new_s;
        for (int c = 0; c < 3; c++) begin
`ifdef WINDOW_EDGE_REPLICATE_EN
            rows_s[0][c] = (cy_r == Y_ZERO) ? cols_s[c].mid : cols_s[c].top;
            rows_s[2][c] = (cy_r == Y_LAST) ? cols_s[c].mid : cols_s[c].bot;
`else
            rows_s[0][c] = (cy_r == Y_ZERO) ? PIX_ZERO : cols_s[c].top;
            rows_s[2][c] = (cy_r == Y_LAST) ? PIX_ZERO : cols_s[c].bot;
`endif
            rows_s[1][c] = cols_s[c].mid;
        end
        for (int r = 0; r < 3; r++) begin
`ifdef WINDOW_EDGE_REPLICATE_EN
            fld_s[r][0] = (cx_r == X_ZERO) ? rows_s[r][1] : rows_s[r][0];
            fld_s[r][2] = (cx_r == X_LAST) ? rows_s[r][1] : rows_s[r][2];
`else
            fld_s[r][0] = (cx_r == X_ZERO) ? PIX_ZERO : rows_s[r][0];
            fld_s[r][2] = (cx_r == X_LAST) ? PIX_ZERO : rows_s[r][2];
`endif
            fld_s[r][1] = rows_s[r][1];
        end
    end

    // Registered window outputs, zero whenever no window is presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb0_r <= WIN_ZERO;
            rgb1_r <= WIN_ZERO;
            rgb2_r <= WIN_ZERO;
        end else if (win_vld_s) begin
            rgb0_r <= pack_row(fld_s[0][0], fld_s[0][1], fld_s[0][2]);
            rgb1_r <= pack_row(fld_s[1][0], fld_s[1][1], fld_s[1][2]);
            rgb2_r <= pack_row(fld_s[2][0], fld_s[2][1], fld_s[2][2]);
        end else begin
            rgb0_r <= WIN_ZERO;
            rgb1_r <= WIN_ZERO;
            rgb2_r <= WIN_ZERO;
        end
    end

    assign bus.busy      = busy_r;
    assign bus.start     = start_r;
    assign bus.cnt_start = cnt_start_r;
    assign bus.done      = done_r;
    assign bus.src_re    = src_re_r;
    assign bus.src_addr  = src_addr_r;
    assign bus.rgb_out0  = rgb0_r;
    assign bus.rgb_out1  = rgb1_r;
    assign bus.rgb_out2  = rgb2_r;

endmodule

// File: doc/window_feeder.md
# window_feeder

Raster-scan window source for the image coprocessor's processing element. It reads a source frame one 12-bit pixel per cycle from single-port image memory and holds the rows it needs in on-chip line buffers. It emits one 3x3 neighbourhood per cycle as three packed 36-bit rows, plus the `start` / `cnt_start` / `done` framing the processing element consumes. It sits between image memory and the processing element: it drives the element's `rgb_in0..2`, `start`, `cnt_start` and `done` inputs.

## Interface
- `IMG_W`, default 160: frame width in pixels, minimum 3.
- `IMG_H`, default 120: frame height in pixels, minimum 3.
- `ADDR_W`, default 15: source address width; IMG_W*IMG_H must be at most 2^ADDR_W.
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `go`  in  1: frame request; sampled only in IDLE.
- `src_re`  out  1: memory read enable.
- `src_addr`  out  ADDR_W: raster read address, y*IMG_W + x.
- `src_rdata`  in  12: read data, valid the cycle after `src_re`.
- `rgb_out0`  out  36: window row y-1; `[35:24]` = x-1, `[23:12]` = x, `[11:0]` = x+1.
- `rgb_out1`  out  36: window row y, same packing.
- `rgb_out2`  out  36: window row y+1, same packing.
- `start`  out  1: one-cycle frame-begin pulse.
- `cnt_start`  out  1: one-cycle pulse; the first window follows in the next cycle.
- `done`  out  1: one-cycle pulse, coincident with the last window.
- `busy`  out  1: high from the `go` acceptance until the end of the `done` cycle.

## Operation
- States:
  - IDLE → PRIME on `go`.
  - PRIME → STREAM after priming.
  - STREAM → IDLE after the last window.
- PRIME:
  - Issue IMG_W+2 reads at addresses 0..IMG_W+1.
  - Row 0 fills a line buffer; row 1 columns 0..1 enter the window pipeline.
- STREAM:
  - Continue reading addresses IMG_W+2..IMG_W*IMG_H-1 consecutively, with no gaps.
  - Each source pixel is read exactly once; the frame totals IMG_W*IMG_H reads.
  - Two line buffers hold rows y-1 and y and rotate at each row end.
  - Present windows for centres (0,0)..(IMG_W-1,IMG_H-1) in raster order, one per cycle, without gaps, including across row boundaries.
- Edge handling, default: zero padding.
  - Any field outside the frame reads 0: row -1, row IMG_H, column -1, column IMG_W.
- Framing:
  - `start` pulses in the first PRIME cycle.
  - `cnt_start` pulses one cycle before the first window.
  - `done` is high while the final window is presented.
- Outside STREAM windows, all `rgb_out*` are 0.
- `go` while busy is ignored.
- `go` held high re-arms immediately after IDLE is re-entered.

## Timing
- Cycle 0 is the cycle in which `go` is high in IDLE.
- `busy` and `start` go high in cycle 1.
- `src_re` is high in cycles 1..IMG_W*IMG_H and low otherwise.
- `cnt_start` is high in cycle IMG_W+3.
- Window (0,0) appears in cycle IMG_W+4; window n appears in cycle IMG_W+4+n.
- `done` is in cycle IMG_W*IMG_H+IMG_W+3; `busy` is low from the following cycle.
- Reset values: every output 0, state IDLE.
- Reset mid-frame aborts the frame immediately, with no `done`. Line buffer contents may be left stale.

## Configuration
- `WINDOW_EDGE_REPLICATE_EN`:
  - Defined: out-of-frame fields take the nearest in-frame pixel, replicating rows first, then columns.
  - Undefined: zero padding.
- Timing and read schedule are identical in both builds.

## Structure
- `coproc_pkg` holds:
  - `PIX_W = 12` and `WIN_W = 36`.
  - The default frame dimensions.
  - The `feeder_state_t` enum (IDLE, PRIME, STREAM).
- Sub-module `line_buffer`: IMG_W x 12 circular buffer with one read and one write per cycle. Instantiate it twice.

## Test plan
Benches use IMG_W=4, IMG_H=3, with source pixel at address a equal to a.
- Pulse `go`:
  - Reads cover addresses 0..11, once each, consecutively.
  - `cnt_start` is in cycle 7; 12 windows follow in cycles 8..19.
  - `done` is in cycle 19.
- Window (1,1):
  - `rgb_out0` = 36'h000001002.
  - `rgb_out1` = 36'h004005006.
  - `rgb_out2` = 36'h008009_00A.
- Window (0,0), zero padding:
  - `rgb_out0` = 0.
  - `rgb_out1` = 36'h000000001.
  - `rgb_out2` = 36'h000004005.
- Window (3,2), zero padding:
  - `rgb_out1` = 36'h00A00B000.
  - `rgb_out2` = 0.
- `WINDOW_EDGE_REPLICATE_EN` defined, window (0,0):
  - `rgb_out0` = `rgb_out1` = 36'h000000001.
  - `rgb_out2` = 36'h004004005.
- Reset asserted in cycle 10, then `go` re-issued:
  - All outputs read 0 during reset, and no `done` is issued for the aborted frame.
  - The second frame matches the first window for window.
  - A `go` pulse while `busy` is ignored.
